// File: rtl/nabp_core.sv
// Nearest-neighbour pixel-driven back-projection engine with accumulator RAM
// and a stallable image readout port.
module nabp_core #(
    parameter int kDataLength            = 16,
    parameter int kImageSize             = 8,
    parameter int kNoOfAngles            = 4,
    parameter int kNoOfBins              = 16,
    parameter int kSinogramAddressLength = 6,
    parameter int kImageAddressLength    = 6,
    parameter int kImageDataLength       = 18
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              sg_kick,
    input  logic [kDataLength-1:0]            sg_val,
    input  logic                              ir_kick,
    input  logic                              ir_enable,
    output logic                              sg_done,
    output logic [kSinogramAddressLength-1:0] sg_addr,
    output logic                              ir_kick_ack,
    output logic                              ir_done,
    output logic [kImageAddressLength-1:0]    ir_addr,
    output logic [kImageDataLength-1:0]       ir_val
);

    localparam int kPix  = kImageSize * kImageSize;
    localparam int kXW   = $clog2(kImageSize);
    localparam int kAW   = $clog2(kNoOfAngles);
    localparam int kCntW = kImageAddressLength + kAW;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_PROJECT,
        S_DRAIN,
        S_DONE,
        S_READOUT
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [kCntW-1:0]               r_cnt;
    logic [kImageAddressLength-1:0] r_idx;
    logic [kImageDataLength-1:0]    r_acc [kPix];

    logic w_clr_last;
    logic w_prj_last;
    logic w_drn_last;
    logic w_rd_last;

    assign w_clr_last = (r_cnt == kCntW'(kPix - 1));
    assign w_prj_last = (r_cnt == kCntW'(kNoOfAngles * kPix - 1));
    assign w_drn_last = (r_cnt == kCntW'(1));
    assign w_rd_last  = (r_idx == kImageAddressLength'(kPix - 1));

    // ---------------------------------------------------------------
    // Control FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (sg_kick) begin
                    w_next = S_CLEAR;
                end else if (ir_kick) begin
                    w_next = S_READOUT;
                end
            end
            S_CLEAR: begin
                if (w_clr_last) begin
                    w_next = S_PROJECT;
                end
            end
            S_PROJECT: begin
                if (w_prj_last) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_drn_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            S_READOUT: begin
                if (ir_enable && w_rd_last) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Phase counter restarts from zero on every state change.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (w_next != r_state) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign sg_done = (r_state == S_DONE);

    // ---------------------------------------------------------------
    // Detector bin for (angle, pixel) held in r_cnt
    // ---------------------------------------------------------------
    logic [kAW-1:0] w_a;
    int             w_x;
    int             w_y;
    int             w_u;
    int             w_v;
    int             w_c;
    int             w_sn;
    int             w_s;
    int             w_t;
    logic           w_inr;
    logic [kSinogramAddressLength-1:0] w_addr;

    assign w_a = r_cnt[kCntW-1 -: kAW];

    always_comb begin
        w_x = int'(r_cnt[kXW-1:0]);
        w_y = int'(r_cnt[2*kXW-1:kXW]);
        w_u = 2 * w_x - (kImageSize - 1);
        w_v = 2 * w_y - (kImageSize - 1);
        case (int'(w_a))
            0:       begin w_c = 64;  w_sn = 0;  end
            1:       begin w_c = 45;  w_sn = 45; end
            2:       begin w_c = 0;   w_sn = 64; end
            3:       begin w_c = -45; w_sn = 45; end
            default: begin w_c = 0;   w_sn = 0;  end
        endcase
        w_s   = w_u * w_c + w_v * w_sn;
        w_t   = ((w_s + 64) >>> 7) + kNoOfBins / 2;
        w_inr = (w_t >= 0) && (w_t < kNoOfBins);
        w_addr = kSinogramAddressLength'(int'(w_a) * kNoOfBins
                 + (w_inr ? w_t : 0));
    end

    // ---------------------------------------------------------------
    // Read-modify-write pipeline: address out, sample back 1 cycle later
    // ---------------------------------------------------------------
    logic [kSinogramAddressLength-1:0] r_sg_addr;
    logic                              r_vld1;
    logic                              r_vld2;
    logic                              r_m1;
    logic                              r_m2;
    logic [kImageAddressLength-1:0]    r_p1;
    logic [kImageAddressLength-1:0]    r_p2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sg_addr <= '0;
            r_vld1    <= 1'b0;
            r_vld2    <= 1'b0;
            r_m1      <= 1'b0;
            r_m2      <= 1'b0;
            r_p1      <= '0;
            r_p2      <= '0;
        end else begin
            r_sg_addr <= (r_state == S_PROJECT) ? w_addr : '0;
            r_vld1    <= (r_state == S_PROJECT);
            r_m1      <= w_inr;
            r_p1      <= r_cnt[kImageAddressLength-1:0];
            r_vld2    <= r_vld1;
            r_m2      <= r_m1;
            r_p2      <= r_p1;
        end
    end

    assign sg_addr = r_sg_addr;

    // Accumulator RAM: contents are not reset, a kick clears them.
    always_ff @(posedge clk) begin
        if (r_state == S_CLEAR) begin
            r_acc[r_cnt[kImageAddressLength-1:0]] <= '0;
        end else if (r_vld2) begin
            r_acc[r_p2] <= r_acc[r_p2]
                + (r_m2 ? kImageDataLength'(sg_val) : '0);
        end
    end

    // ---------------------------------------------------------------
    // Image readout
    // ---------------------------------------------------------------
    logic                           r_ir_ack;
    logic                           r_ir_done;
    logic [kImageAddressLength-1:0] r_ir_addr;
    logic [kImageDataLength-1:0]    r_ir_val;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ir_ack  <= 1'b0;
            r_ir_done <= 1'b0;
            r_ir_addr <= '0;
            r_ir_val  <= '0;
            r_idx     <= '0;
        end else begin
            r_ir_ack  <= (r_state == S_IDLE) && ir_kick && !sg_kick;
            r_ir_done <= 1'b0;
            if (r_state != S_READOUT) begin
                r_idx <= '0;
            end else if (ir_enable) begin
                r_ir_addr <= r_idx;
                r_ir_val  <= r_acc[r_idx];
                r_ir_done <= w_rd_last;
                r_idx     <= r_idx + 1'b1;
            end
        end
    end

    assign ir_kick_ack = r_ir_ack;
    assign ir_done     = r_ir_done;
    assign ir_addr     = r_ir_addr;
    assign ir_val      = r_ir_val;

endmodule

// File: tb/tb_nabp_core.sv
// Directed/random bench for nabp_core against an arithmetic back-projection
// model with a synchronous sinogram LUT.
module tb_nabp_core;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sg_kick = 1'b0;
    logic [15:0] sg_val;
    logic        ir_kick = 1'b0;
    logic        ir_enable = 1'b0;
    logic        sg_done;
    logic [5:0]  sg_addr;
    logic        ir_kick_ack;
    logic        ir_done;
    logic [5:0]  ir_addr;
    logic [17:0] ir_val;

    nabp_core dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .sg_kick     (sg_kick),
        .sg_val      (sg_val),
        .ir_kick     (ir_kick),
        .ir_enable   (ir_enable),
        .sg_done     (sg_done),
        .sg_addr     (sg_addr),
        .ir_kick_ack (ir_kick_ack),
        .ir_done     (ir_done),
        .ir_addr     (ir_addr),
        .ir_val      (ir_val)
    );

    always #5 clk = ~clk;

    logic [15:0] lut [64];
    always @(posedge clk) sg_val <= lut[sg_addr];

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int ack_cnt = 0;
    bit logging = 0;
    int addr_q[$];

    always @(negedge clk) begin
        if (sg_done) done_cnt++;
        if (ir_kick_ack) ack_cnt++;
        if (logging) addr_q.push_back(int'(sg_addr));
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // floor(n/128) with true floor semantics for negative n
    function automatic int fdiv128(int n);
        if (n >= 0) return n / 128;
        return -((-n + 127) / 128);
    endfunction

    function automatic int bin_t(int a, int p);
        int cq[4] = '{64, 45, 0, -45};
        int sq[4] = '{0, 45, 64, 45};
        int u = 2 * (p % 8) - 7;
        int v = 2 * (p / 8) - 7;
        return fdiv128(u * cq[a] + v * sq[a] + 64) + 8;
    endfunction

    function automatic int model_addr(int a, int p);
        int t = bin_t(a, p);
        if (t < 0 || t >= 16) return a * 16;
        return a * 16 + t;
    endfunction

    function automatic logic [17:0] model_pix(int p);
        int sum = 0;
        for (int a = 0; a < 4; a++) begin
            int t = bin_t(a, p);
            if (t >= 0 && t < 16) sum += int'(lut[a * 16 + t]);
        end
        return 18'(sum);
    endfunction

    task automatic run_bp(input bit spam, input bit both);
        int d0 = done_cnt;
        int a0 = ack_cnt;
        int n = 0;
        bit got = 0;
        sg_kick = 1'b1;
        ir_kick = both;
        tick();
        sg_kick = 1'b0;
        ir_kick = 1'b0;
        if (both) chk("dual_kick_no_ack", ir_kick_ack, 1'b0);
        while (!got && n < 400) begin
            if (spam && n >= 80 && n < 90) begin
                sg_kick = 1'b1;
                ir_kick = (n == 85);
            end else begin
                sg_kick = 1'b0;
                ir_kick = 1'b0;
            end
            tick();
            n++;
            if (sg_done) got = 1;
        end
        sg_kick = 1'b0;
        ir_kick = 1'b0;
        chk("sg_done_seen", got, 1'b1);
        chk("latency_le_324", (n <= 324), 1'b1);
        repeat (4) tick();
        chk("single_sg_done", done_cnt - d0, 1);
        if (spam || both) chk("busy_kick_no_ack", ack_cnt - a0, 0);
    endtask

    task automatic readout(input bit rnd_en);
        int a0 = ack_cnt;
        int idx = 0;
        int n = 0;
        bit en;
        bit have = 0;
        logic [24:0] hold = '0;
        ir_enable = 1'b0;
        ir_kick = 1'b1;
        tick();
        ir_kick = 1'b0;
        chk("ir_kick_ack", ir_kick_ack, 1'b1);
        while (idx < 64 && n < 1000) begin
            if (!rnd_en) en = 1'b1;
            else if (n < 3) en = (n != 1);
            else en = 1'($urandom_range(0, 1));
            ir_enable = en;
            tick();
            n++;
            if (n == 2) chk("ack_dropped", ir_kick_ack, 1'b0);
            if (en) begin
                hold = {idx[5:0], model_pix(idx), (idx == 63)};
                chk("pixel", {ir_addr, ir_val, ir_done}, hold);
                hold[0] = 1'b0;
                have = 1;
                idx++;
            end else if (have) begin
                chk("stall_hold", {ir_addr, ir_val, ir_done}, hold);
            end
        end
        chk("readout_count", idx, 64);
        ir_enable = 1'b0;
        tick();
        chk("ir_done_clear", ir_done, 1'b0);
        chk("ack_one_pulse", ack_cnt - a0, 1);
    endtask

    initial begin
        int k;
        int mism;
        int d0;

        for (int i = 0; i < 64; i++) lut[i] = 16'd1;
        reset_n = 1'b0;
        repeat (3) tick();
        chk("rst_sg_done", sg_done, 1'b0);
        chk("rst_sg_addr", sg_addr, 6'd0);
        chk("rst_ack", ir_kick_ack, 1'b0);
        chk("rst_ir_done", ir_done, 1'b0);
        chk("rst_ir_addr", ir_addr, 6'd0);
        chk("rst_ir_val", ir_val, 18'd0);
        reset_n = 1'b1;
        tick();

        // all ones: every pixel sees four samples
        run_bp(1'b0, 1'b0);
        readout(1'b0);

        // sample equals address: exposes the bin mapping
        for (int i = 0; i < 64; i++) lut[i] = 16'(i);
        addr_q.delete();
        logging = 1;
        run_bp(1'b0, 1'b0);
        logging = 0;
        k = -1;
        for (int i = 0; i < addr_q.size(); i++) begin
            if (k < 0 && addr_q[i] == model_addr(0, 0)) k = i;
        end
        mism = 256;
        if (k >= 0 && k + 256 <= addr_q.size()) begin
            mism = 0;
            for (int j = 0; j < 256; j++) begin
                if (addr_q[k + j] != model_addr(j / 64, j % 64)) mism++;
            end
            chk("p0_a1_addr", addr_q[k + 64], 19);
            chk("p7_a0_addr", addr_q[k + 7], 12);
        end
        chk("addr_seq_mismatches", mism, 0);
        readout(1'b0);

        // full-scale samples: widest accumulator value
        for (int i = 0; i < 64; i++) lut[i] = 16'hFFFF;
        run_bp(1'b0, 1'b0);
        readout(1'b0);

        // random data, dual kick, kicks while busy, stalled readout
        for (int i = 0; i < 64; i++) lut[i] = 16'($urandom);
        run_bp(1'b1, 1'b1);
        readout(1'b1);
        run_bp(1'b0, 1'b0);
        readout(1'b0);

        // asynchronous reset mid-projection
        for (int i = 0; i < 64; i++) lut[i] = 16'($urandom);
        sg_kick = 1'b1;
        tick();
        sg_kick = 1'b0;
        repeat (100) tick();
        #2 reset_n = 1'b0;
        #1;
        chk("arst_sg_addr", sg_addr, 6'd0);
        chk("arst_sg_done", sg_done, 1'b0);
        chk("arst_outputs", {ir_kick_ack, ir_done, ir_addr, ir_val}, 26'd0);
        repeat (2) tick();
        reset_n = 1'b1;
        d0 = done_cnt;
        repeat (400) tick();
        chk("arst_no_sg_done", done_cnt - d0, 0);
        run_bp(1'b0, 1'b0);
        readout(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
